gate_stim_checker: RTL

- Synthesizable stimulus/response block for the two-input, seven-output logic-gate unit; it plays the opposite role to the stimulus-only simulation bench.
- Drives inputs a/b through all four combinations in order 00, 01, 10, 11.
- Samples the seven gate outputs after a settle window and compares them with internally computed expected values.
- Reports pass/fail, an error count and the first failing vector. Used for on-board self-test of the gate unit.

---
 rtl/gate_chk_pkg.sv | 14 +
 rtl/gate_expected_lut.sv | 18 +
 rtl/gate_stim_checker.sv | 104 ++++++++++
 3 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and reference constants for the gate-unit stimulus/response checker.
package gate_chk_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam int OBS_W = 7;

  // Packed {o7..o1} for each {a,b} vector.
  localparam logic [OBS_W-1:0] EXP_00 = 7'h6C;
  localparam logic [OBS_W-1:0] EXP_01 = 7'h56;
  localparam logic [OBS_W-1:0] EXP_10 = 7'h16;
  localparam logic [OBS_W-1:0] EXP_11 = 7'h23;

endpackage

// File: rtl/gate_expected_lut.sv
// Combinational lookup of the seven expected gate outputs for one {a,b} vector.
module gate_expected_lut
  import gate_chk_pkg::*;
(
  input  logic [1:0]       vec,
  output logic [OBS_W-1:0] expected
);

  always_comb begin
    unique case (vec)
      2'b00: expected = EXP_00;
      2'b01: expected = EXP_01;
      2'b10: expected = EXP_10;
      2'b11: expected = EXP_11;
    endcase
  end

endmodule

// File: rtl/gate_stim_checker.sv
// Walks a/b through 00,01,10,11, samples the gate outputs after a settle
// window and reports pass/fail, a saturating error count and the first failing vector.
module gate_stim_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic [OBS_W-1:0] obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_seen,
  output logic [1:0]       fail_vec
);

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_t           state;
  logic [1:0]       vec;
  logic [3:0]       settle_cnt;
  logic             start_q;
  logic [OBS_W-1:0] expected;
  logic             mismatch;

  gate_expected_lut u_lut (
    .vec      (vec),
    .expected (expected)
  );

  assign mismatch = (obs != expected);
  assign a        = vec[1];
  assign b        = vec[0];

  // NOTE: all state uses non-blocking assignment so every register samples
  // pre-edge values; reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= 2'b00;
      settle_cnt <= 4'd0;
      start_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_seen  <= 1'b0;
      fail_vec   <= 2'b00;
    end else begin
      start_q <= start;
      done    <= 1'b0;
      unique case (state)
        // Only a fresh rising start launches a run, so a held start runs once.
        IDLE: begin
          if (start && !start_q) begin
            vec        <= 2'b00;
            err_cnt    <= '0;
            fail_seen  <= 1'b0;
            fail_vec   <= 2'b00;
            pass       <= 1'b0;
            settle_cnt <= SETTLE_LOAD;
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt <= 4'd1) state <= CHECK;
          else settle_cnt <= settle_cnt - 4'd1;
        end
        CHECK: begin
          if (mismatch) begin
            if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
            if (!fail_seen) begin
              fail_seen <= 1'b1;
              fail_vec  <= vec;
            end
          end
          if (vec == 2'd3) begin
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            vec        <= vec + 2'd1;
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          pass  <= (err_cnt == '0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
